axi_cmd_initiator: RTL and testbench

- Single-outstanding AXI4 initiator that turns a simple command/response handshake into single-beat AXI transactions.
- Drives a cluster's inbound port (narrow_in or wide_in) in the testharness, which the harness currently ties to zero. It is the requester counterpart to the tb_memory_axi responders on the outbound ports.
- Lets benches preload TCDM, poke peripheral registers and read results back over the real slave path.

---
 rtl/axi_cmd_initiator_pkg.sv | 102 ++++++++++
 rtl/axi_cmd_initiator.sv | 176 +++++++++++++++++
 tb/tb_axi_cmd_initiator.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cmd_initiator_pkg.sv
// Shared types for the single-outstanding AXI command initiator: FSM states,
// AXI response/burst encodings and the default AXI channel/request/response structs.
package axi_cmd_initiator_pkg;

    localparam int unsigned AXI_ADDR_W = 48;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 2;
    localparam int unsigned AXI_USER_W = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WAIT_B,
        RD_ADDR,
        WAIT_R,
        RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;

    // AXI size field: log2 of the number of bytes per beat.
    function automatic logic [2:0] beat_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_cmd_initiator.sv
// Single-outstanding AXI4 initiator: one command in, one single-beat AXI
// transaction out, one response back. Handshakes are valid/ready: a transfer
// happens on a rising edge where both are high; valid never drops before ready.
module axi_cmd_initiator
    import axi_cmd_initiator_pkg::*;
#(
    parameter int unsigned AxiAddrWidth  = AXI_ADDR_W,
    parameter int unsigned AxiDataWidth  = AXI_DATA_W,
    parameter int unsigned AxiIdWidth    = AXI_ID_W,
    parameter int unsigned AxiUserWidth  = AXI_USER_W,
    parameter int unsigned TxnId         = 0,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         req_t         = axi_req_t,
    parameter type         rsp_t         = axi_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
    input  logic [AxiDataWidth-1:0]   cmd_wdata_i,
    input  logic [AxiDataWidth/8-1:0] cmd_strb_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [AxiDataWidth-1:0]   rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      timeout_o,
    output req_t                      req_o,
    input  rsp_t                      rsp_i
);

    localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0]   CntMax = CntWidth'(TimeoutCycles);
    localparam logic [AxiIdWidth-1:0] IdVal  = AxiIdWidth'(TxnId);
    localparam logic [2:0]            SizeVal = beat_size(AxiDataWidth);

    state_e                    state_q, state_d;
    logic [AxiAddrWidth-1:0]   addr_q;
    logic [AxiDataWidth-1:0]   wdata_q;
    logic [AxiDataWidth/8-1:0] strb_q;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AxiDataWidth-1:0]   rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;
    logic                      waiting;
    logic                      cmd_hs;

    // Response fields that carry no meaning for this initiator.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{rsp_i.b.resp[0], rsp_i.b.user, rsp_i.r.resp[0], rsp_i.r.user};

    assign cmd_hs  = (state_q == IDLE) && cmd_valid_i;
    assign waiting = (state_q == WR_ADDR_DATA) || (state_q == WAIT_B) ||
                     (state_q == RD_ADDR) || (state_q == WAIT_R);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            if (cmd_hs) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                strb_q  <= cmd_strb_i;
            end
        end
    end

    // Next state and all outputs; AXI fields are only non-zero while their channel is live.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_o       = '0;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write_i ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                req_o.aw_valid  = !aw_done_q;
                req_o.aw.id     = IdVal;
                req_o.aw.addr   = addr_q;
                req_o.aw.len    = 8'd0;
                req_o.aw.size   = SizeVal;
                req_o.aw.burst  = BURST_INCR;
                req_o.aw.user   = {AxiUserWidth{1'b0}};
                req_o.w_valid   = !w_done_q;
                req_o.w.data    = wdata_q;
                req_o.w.strb    = strb_q;
                req_o.w.last    = 1'b1;
                if (!aw_done_q && rsp_i.aw_ready) aw_done_d = 1'b1;
                if (!w_done_q && rsp_i.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)        state_d   = WAIT_B;
            end
            WAIT_B: begin
                req_o.b_ready = 1'b1;
                if (rsp_i.b_valid) begin
                    err_d   = rsp_i.b.resp[1] || (rsp_i.b.id != IdVal);
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RD_ADDR: begin
                req_o.ar_valid = 1'b1;
                req_o.ar.id    = IdVal;
                req_o.ar.addr  = addr_q;
                req_o.ar.len   = 8'd0;
                req_o.ar.size  = SizeVal;
                req_o.ar.burst = BURST_INCR;
                if (rsp_i.ar_ready) state_d = WAIT_R;
            end
            WAIT_R: begin
                req_o.r_ready = 1'b1;
                if (rsp_i.r_valid) begin
                    err_d   = rsp_i.r.resp[1] || (rsp_i.r.id != IdVal) || !rsp_i.r.last;
                    rdata_d = rsp_i.r.data;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait-cycle counter saturates at the limit; the timeout flag is sticky until reset.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((TimeoutCycles != 0) && waiting && (cnt_d == CntMax)) begin
            timeout_d = 1'b1;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_axi_cmd_initiator.sv
// Directed bench for axi_cmd_initiator; the bench itself plays the AXI slave.
module tb_axi_cmd_initiator;
    import axi_cmd_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [47:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        timeout;
    axi_req_t    req;
    axi_rsp_t    rsp;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    axi_cmd_initiator #(
        .TimeoutCycles(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_wdata_i(cmd_wdata),
        .cmd_strb_i (cmd_strb),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .busy_o     (busy),
        .timeout_o  (timeout),
        .req_o      (req),
        .rsp_i      (rsp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle, then scramble the inputs to prove they are latched.
    task automatic issue(input logic wr, input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = 48'hFFFF_FFFF_FFFF;
        cmd_wdata = {$urandom, $urandom};
        cmd_strb  = 8'h00;
        chk("busy_after_cmd", busy, 1'b1);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_after_rsp", cmd_ready, 1'b1);
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    // Zero-wait write: AW/W in cycle 1, B in cycle 2, response in cycle 3.
    task automatic do_write(input logic [47:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [1:0] bid, input logic [1:0] bresp, input logic exp_err);
        issue(1'b1, a, d, s);
        chk("wr_aw_valid", req.aw_valid, 1'b1);
        chk("wr_w_valid", req.w_valid, 1'b1);
        chk("wr_aw_addr", req.aw.addr, a);
        chk("wr_aw_size", req.aw.size, 3'd3);
        chk("wr_aw_burst", req.aw.burst, BURST_INCR);
        chk("wr_aw_len", req.aw.len, 8'd0);
        chk("wr_aw_id", req.aw.id, 2'd0);
        chk("wr_w_data", req.w.data, d);
        chk("wr_w_strb", req.w.strb, s);
        chk("wr_w_last", req.w.last, 1'b1);
        chk("wr_b_ready_early", req.b_ready, 1'b0);
        rsp.aw_ready = 1'b1;
        rsp.w_ready  = 1'b1;
        tick();
        rsp.aw_ready = 1'b0;
        rsp.w_ready  = 1'b0;
        chk("wr_aw_drop", req.aw_valid, 1'b0);
        chk("wr_w_drop", req.w_valid, 1'b0);
        chk("wr_b_ready", req.b_ready, 1'b1);
        chk("wr_rsp_early", rsp_valid, 1'b0);
        rsp.b_valid = 1'b1;
        rsp.b.id    = bid;
        rsp.b.resp  = bresp;
        tick();
        rsp.b_valid = 1'b0;
        chk("wr_rsp_valid_c3", rsp_valid, 1'b1);
        chk("wr_rsp_err", rsp_err, exp_err);
        chk("wr_rsp_rdata", rsp_rdata, 64'd0);
        chk("wr_b_ready_resp", req.b_ready, 1'b0);
        consume();
    endtask

    // Zero-wait read: AR in cycle 1, R in cycle 2, response in cycle 3.
    task automatic do_read(input logic [47:0] a, input logic [63:0] d, input logic [1:0] rid,
                           input logic [1:0] rresp, input logic rlast, input logic exp_err);
        issue(1'b0, a, 64'd0, 8'd0);
        chk("rd_ar_valid", req.ar_valid, 1'b1);
        chk("rd_ar_addr", req.ar.addr, a);
        chk("rd_ar_size", req.ar.size, 3'd3);
        chk("rd_aw_quiet", req.aw_valid, 1'b0);
        chk("rd_r_ready_early", req.r_ready, 1'b0);
        rsp.ar_ready = 1'b1;
        tick();
        rsp.ar_ready = 1'b0;
        chk("rd_ar_drop", req.ar_valid, 1'b0);
        chk("rd_r_ready", req.r_ready, 1'b1);
        rsp.r_valid = 1'b1;
        rsp.r.id    = rid;
        rsp.r.data  = d;
        rsp.r.resp  = rresp;
        rsp.r.last  = rlast;
        tick();
        rsp.r_valid = 1'b0;
        chk("rd_rsp_valid_c3", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, d);
        chk("rd_rsp_err", rsp_err, exp_err);
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        rsp       = '0;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_zero", |req, 1'b0);
        rst = 1'b0;
        tick();

        // Write then read back the same word.
        do_write(48'h0000_1000_0000, 64'h1122_3344_5566_7788, 8'hFF, 2'd0, RESP_OKAY, 1'b0);
        do_read(48'h0000_1000_0000, 64'h1122_3344_5566_7788, 2'd0, RESP_OKAY, 1'b1, 1'b0);

        // Error sources: wrong R id, missing R last, B SLVERR (also clears rdata).
        do_read(48'h0000_2000_0008, 64'hDEAD_BEEF_0000_0001, 2'd1, RESP_OKAY, 1'b1, 1'b1);
        do_read(48'h0000_2000_0010, 64'h0123_4567_89AB_CDEF, 2'd0, RESP_EXOKAY, 1'b0, 1'b1);
        do_write(48'h0000_3000_0000, 64'hCAFE_F00D_0000_0042, 8'h0F, 2'd0, RESP_SLVERR, 1'b1);
        do_read(48'h0000_2000_0018, 64'h5555_AAAA_5555_AAAA, 2'd0, RESP_DECERR, 1'b1, 1'b1);

        // AW stalled 5 cycles while W goes through in cycle 1.
        issue(1'b1, 48'h0000_4000_0040, 64'hA1A2_A3A4_A5A6_A7A8, 8'hF0);
        rsp.w_ready = 1'b1;
        chk("stall_w_valid_c1", req.w_valid, 1'b1);
        tick();
        rsp.w_ready = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            chk("stall_aw_valid", req.aw_valid, 1'b1);
            chk("stall_aw_addr", req.aw.addr, 48'h0000_4000_0040);
            chk("stall_w_done", req.w_valid, 1'b0);
            chk("stall_b_ready", req.b_ready, 1'b0);
            tick();
        end
        rsp.aw_ready = 1'b1;
        chk("stall_aw_valid_c6", req.aw_valid, 1'b1);
        tick();
        rsp.aw_ready = 1'b0;
        chk("stall_wait_b_c7", req.b_ready, 1'b1);
        chk("stall_aw_drop", req.aw_valid, 1'b0);
        rsp.b_valid = 1'b1;
        rsp.b.id    = 2'd0;
        rsp.b.resp  = RESP_OKAY;
        tick();
        rsp.b_valid = 1'b0;
        chk("stall_rsp_valid", rsp_valid, 1'b1);
        chk("stall_rsp_err", rsp_err, 1'b0);
        chk("stall_no_timeout_7", timeout, 1'b0);
        consume();

        // Response held for 10 cycles with a competing command present.
        issue(1'b0, 48'h0000_5000_0000, 64'd0, 8'd0);
        rsp.ar_ready = 1'b1;
        tick();
        rsp.ar_ready = 1'b0;
        rsp.r_valid = 1'b1;
        rsp.r.id    = 2'd0;
        rsp.r.data  = 64'hA5A5_5A5A_0F0F_F0F0;
        rsp.r.resp  = RESP_OKAY;
        rsp.r.last  = 1'b1;
        tick();
        rsp.r_valid = 1'b0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_rdata", rsp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
            chk("hold_rsp_err", rsp_err, 1'b0);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_r_ready", req.r_ready, 1'b0);
            tick();
        end
        chk("hold_cmd_ready_hs", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("hold_cmd_ready_after", cmd_ready, 1'b1);
        chk("hold_rsp_valid_after", rsp_valid, 1'b0);
        chk("hold_no_aw", req.aw_valid, 1'b0);

        // Timeout: AR never accepted.
        issue(1'b0, 48'h0000_6000_0000, 64'd0, 8'd0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("to_not_yet", timeout, 1'b0);
            chk("to_ar_held", req.ar_valid, 1'b1);
        end
        tick();
        chk("to_set_8", timeout, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_sticky", timeout, 1'b1);
            chk("to_ar_still", req.ar_valid, 1'b1);
            chk("to_ar_addr", req.ar.addr, 48'h0000_6000_0000);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_rst_ar", req.ar_valid, 1'b0);
        chk("to_rst_timeout", timeout, 1'b0);
        chk("to_rst_idle", cmd_ready, 1'b1);

        // Reset during WAIT_R abandons the read.
        issue(1'b0, 48'h0000_7000_0000, 64'd0, 8'd0);
        rsp.ar_ready = 1'b1;
        tick();
        rsp.ar_ready = 1'b0;
        chk("wr_rst_in_wait_r", req.r_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wr_cmd_ready", cmd_ready, 1'b1);
        chk("rst_wr_busy", busy, 1'b0);
        chk("rst_wr_r_ready", req.r_ready, 1'b0);
        chk("rst_wr_req_zero", |req, 1'b0);
        chk("rst_wr_rsp_valid", rsp_valid, 1'b0);

        // Normal operation resumes after the abandoned read.
        do_read(48'h0000_7000_0008, 64'h7777_8888_9999_0000, 2'd0, RESP_OKAY, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
